// File: rtl/add_round_key_stage.sv
// ---------------------------------------------------------------------------
// add_round_key_stage
//   Registered AddRoundKey stage of the AES-128 round datapath. It selects
//   either the MixColumns output or the bypass state (whitening and final
//   round), XORs it with the round key, and tags the result with its round
//   index. A two-entry skid buffer (output register + skid register) sits
//   behind valid/ready handshakes so the pipeline can stall without loss.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid       upstream beat valid
//   in_ready       stage can accept a beat (registered)
//   in_first       beat is round 0 of a new block
//   in_state_mc    MixColumns output (rounds 1..NR-1)
//   in_state_sr    plaintext (round 0) / ShiftRows output (round NR)
//   round_key      round key for the presented beat
//   out_valid      output beat valid
//   out_ready      downstream accepts output
//   out_state      selected state XOR round key
//   out_round      round index of out_state
//   out_last       out_round == NR
//   err_seq        sticky sequencing error flag
// ---------------------------------------------------------------------------
module add_round_key_stage #(
    parameter int unsigned NR      = 10,
    parameter int unsigned ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic [127:0]       in_state_mc,
    input  logic [127:0]       in_state_sr,
    input  logic [127:0]       round_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last,
    output logic               err_seq
);

    localparam int unsigned STATE_W = 128;
    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] ONE_RND  = ROUND_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [ROUND_W-1:0] round;
        logic               last;
    } entry_t;

    // Sequencer state
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [ROUND_W-1:0] r_rnd;
    logic [ROUND_W-1:0] w_rnd_nxt;
    logic               r_err;
    logic               w_err_nxt;

    // Buffer state: r_out is the head, r_skid holds the second beat
    entry_t             r_out;
    entry_t             w_out_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    entry_t             r_skid;
    entry_t             w_skid_nxt;
    logic               r_skid_valid;
    logic               w_skid_valid_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;

    // Datapath
    logic               w_accept;
    logic               w_enq;
    logic               w_out_free;
    logic [ROUND_W-1:0] w_cur_rnd;
    logic [STATE_W-1:0] w_sel;
    entry_t             w_entry;

    assign w_accept = in_valid & r_in_ready;

    // Round tag of the presented beat; in_first always restarts at round 0
    assign w_cur_rnd = in_first ? '0 : r_rnd;

    // Whitening and final round bypass MixColumns
    assign w_sel = ((w_cur_rnd == '0) || (w_cur_rnd == LAST_RND)) ? in_state_sr : in_state_mc;

    assign w_entry.state = w_sel ^ round_key;
    assign w_entry.round = w_cur_rnd;
    assign w_entry.last  = (w_cur_rnd == LAST_RND);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rnd   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Block sequencing: decides whether an accepted beat is enqueued
    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_err_nxt   = r_err;
        w_enq       = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_first) begin
                        w_enq       = 1'b1;
                        w_rnd_nxt   = ONE_RND;
                        w_state_nxt = ST_RUN;
                    end else begin
                        // Stray beat outside a block is dropped
                        w_err_nxt = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_enq = 1'b1;
                    if (in_first) begin
                        // Abort current block; this beat starts a new one
                        w_err_nxt = 1'b1;
                        w_rnd_nxt = ONE_RND;
                    end else if (r_rnd == LAST_RND) begin
                        w_rnd_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rnd_nxt = r_rnd + ONE_RND;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rnd_nxt   = '0;
                end
            endcase
        end
    end

    // Head slot can take new data when empty or being dequeued this cycle
    assign w_out_free = ~r_out_valid | out_ready;

    // Skid buffer next-state
    always_comb begin
        w_out_nxt        = r_out;
        w_out_valid_nxt  = r_out_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid advances to head; a new beat refills the skid
                w_out_nxt       = r_skid;
                w_out_valid_nxt = 1'b1;
                if (w_enq) begin
                    w_skid_nxt = w_entry;
                end else begin
                    w_skid_valid_nxt = 1'b0;
                end
            end else if (w_enq) begin
                w_out_nxt       = w_entry;
                w_out_valid_nxt = 1'b1;
            end else begin
                // Data fields hold their last value when empty
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_enq) begin
            w_skid_nxt       = w_entry;
            w_skid_valid_nxt = 1'b1;
        end
        // Ready reflects next-cycle occupancy, so it drops exactly when full
        w_in_ready_nxt = ~(w_out_valid_nxt & w_skid_valid_nxt);
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_out        <= w_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= w_in_ready_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out.state;
    assign out_round = r_out.round;
    assign out_last  = r_out.last;
    assign err_seq   = r_err;

endmodule

// File: tb/tb_add_round_key_stage.sv
// ---------------------------------------------------------------------------
// tb_add_round_key_stage
//   Directed, table-driven bench for add_round_key_stage: an 11-beat block
//   table with hand-computed results, plus sequences for stray beats,
//   mid-block restart, back-pressure and mid-block reset.
// ---------------------------------------------------------------------------
module tb_add_round_key_stage;

    localparam int unsigned NR      = 10;
    localparam int unsigned ROUND_W = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_first;
    logic [127:0]       in_state_mc;
    logic [127:0]       in_state_sr;
    logic [127:0]       round_key;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_state;
    logic [ROUND_W-1:0] out_round;
    logic               out_last;
    logic               err_seq;

    add_round_key_stage #(.NR(NR), .ROUND_W(ROUND_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_state_mc (in_state_mc),
        .in_state_sr (in_state_sr),
        .round_key   (round_key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .out_round   (out_round),
        .out_last    (out_last),
        .err_seq     (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         first;
        logic [127:0] sr;
        logic [127:0] mc;
        logic [127:0] key;
        logic [127:0] exp_state;
        int           exp_round;
        logic         exp_last;
    } vec_t;

    vec_t tbl [11];
    int   n_vec;
    int   n_err;

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in_first    = tbl[i].first;
        in_state_sr = tbl[i].sr;
        in_state_mc = tbl[i].mc;
        round_key   = tbl[i].key;
    endtask

    // Present table beat i with out_ready high and check it one cycle later
    task automatic send_chk(input int i, input string tag);
        drive(i);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_n($sformatf("%s_valid", tag), int'(out_valid), 1);
        chk_w($sformatf("%s_state", tag), out_state, tbl[i].exp_state);
        chk_n($sformatf("%s_round", tag), int'(out_round), tbl[i].exp_round);
        chk_n($sformatf("%s_last", tag), int'(out_last), int'(tbl[i].exp_last));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] kb;
        logic       acc;
        logic       xfer;
        int         idx;
        int         n_out;
        int         seq [7];
        int         seq_rnd [7];

        n_vec = 0;
        n_err = 0;

        // Round 0 and 1: FIPS-197 Appendix B values
        tbl[0].first     = 1'b1;
        tbl[0].sr        = 128'h3243f6a8885a308d313198a2e0370734;
        tbl[0].mc        = {16{8'haa}};
        tbl[0].key       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tbl[0].exp_state = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        tbl[0].exp_round = 0;
        tbl[0].exp_last  = 1'b0;

        tbl[1].first     = 1'b0;
        tbl[1].sr        = {16{8'hff}};
        tbl[1].mc        = 128'h046681e5e0cb199a48f8d37a2806264c;
        tbl[1].key       = 128'ha0fafe1788542cb123a339392a6c7605;
        tbl[1].exp_state = 128'ha49c7ff2689f352b6b5bea43026a5049;
        tbl[1].exp_round = 1;
        tbl[1].exp_last  = 1'b0;

        // Rounds 2..9: byte-replicated patterns, sr poisoned to catch a wrong select
        for (int r = 2; r <= 9; r++) begin
            b  = 8'(r * 17);
            kb = 8'(8'h5a + r);
            tbl[r].first     = 1'b0;
            tbl[r].sr        = {16{8'hff}};
            tbl[r].mc        = {16{b}};
            tbl[r].key       = {16{kb}};
            tbl[r].exp_state = {16{b ^ kb}};
            tbl[r].exp_round = r;
            tbl[r].exp_last  = 1'b0;
        end

        // Final round takes the ShiftRows bypass
        tbl[10].first     = 1'b0;
        tbl[10].sr        = 128'h3925841d02dc09fbdc118597196a0b32;
        tbl[10].mc        = {16{8'h55}};
        tbl[10].key       = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        tbl[10].exp_state = 128'he9317db5cb322c723d2e895faf090794;
        tbl[10].exp_round = 10;
        tbl[10].exp_last  = 1'b1;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_first    = 1'b0;
        in_state_mc = '0;
        in_state_sr = '0;
        round_key   = '0;
        out_ready   = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_n("rst_out_valid", int'(out_valid), 0);
        chk_n("rst_in_ready", int'(in_ready), 1);
        chk_w("rst_out_state", out_state, '0);
        chk_n("rst_out_round", int'(out_round), 0);
        chk_n("rst_out_last", int'(out_last), 0);
        chk_n("rst_err_seq", int'(err_seq), 0);
        rst_n = 1'b1;

        // Full 11-beat block at one beat per cycle
        for (int i = 0; i < 11; i++) begin
            send_chk(i, $sformatf("blk%0d", i));
            chk_n($sformatf("blk%0d_in_ready", i), int'(in_ready), 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_n("blk_drained_valid", int'(out_valid), 0);
        chk_w("blk_hold_state", out_state, tbl[10].exp_state);
        chk_n("blk_err_clean", int'(err_seq), 0);

        // Stray beat in IDLE (block completed) is dropped and flagged
        drive(1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_n("stray_dropped", int'(out_valid), 0);
        chk_n("stray_err", int'(err_seq), 1);
        @(posedge clk);
        #1;
        chk_n("stray_still_empty", int'(out_valid), 0);

        do_reset();
        chk_n("rst2_err_cleared", int'(err_seq), 0);

        // Restart at round 5: beat is tagged round 0, next beat is round 1
        seq     = '{0, 1, 2, 3, 4, 0, 1};
        seq_rnd = '{0, 1, 2, 3, 4, 0, 1};
        for (int k = 0; k < 7; k++) begin
            send_chk(seq[k], $sformatf("abort%0d", k));
            chk_n($sformatf("abort%0d_rnd", k), int'(out_round), seq_rnd[k]);
            chk_n($sformatf("abort%0d_err", k), int'(err_seq), (k >= 5) ? 1 : 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        do_reset();

        // Back-pressure: 5 stalled cycles with in_valid held high
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(idx);
            in_valid = 1'b1;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            chk_w($sformatf("bp_hold%0d", c), out_state, tbl[0].exp_state);
        end
        chk_n("bp_accepted", idx, 2);
        chk_n("bp_in_ready", int'(in_ready), 0);
        chk_n("bp_out_valid", int'(out_valid), 1);
        chk_n("bp_out_round", int'(out_round), 0);

        // Release: six beats must emerge in order, none lost or repeated
        out_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            if (idx < 6) begin
                drive(idx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc  = in_valid & in_ready;
            xfer = out_valid & out_ready;
            if (xfer) begin
                chk_w($sformatf("bp_out%0d_state", n_out), out_state, tbl[n_out].exp_state);
                chk_n($sformatf("bp_out%0d_round", n_out), int'(out_round), tbl[n_out].exp_round);
                n_out++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk_n("bp_out_count", n_out, 6);
        chk_n("bp_drained", int'(out_valid), 0);

        do_reset();

        // Reset mid-block with both entries occupied
        out_ready = 1'b0;
        drive(0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_n("mid_full_in_ready", int'(in_ready), 0);
        chk_n("mid_full_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_n("mid_rst_valid", int'(out_valid), 0);
        chk_n("mid_rst_in_ready", int'(in_ready), 1);
        chk_w("mid_rst_state", out_state, '0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_chk(0, "post_rst");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_n("post_rst_drained", int'(out_valid), 0);
        chk_n("post_rst_err", int'(err_seq), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
